// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 32-bit instructions, owns the PC and instruction
// register, steps the decoder's execution cycle, and redirects to the trap
// vector on undefined instructions or fetch bus errors.
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00,
   parameter logic [63:0] TRAP_PC  = 64'hFFFF_FFFF_FFFF_FE00
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic [63:0] iadr_o,
   output logic        istb_o,
   input  logic        iack_i,
   input  logic        ierr_i,
   input  logic [31:0] idat_i,
   output logic [31:0] ir_o,
   output logic [2:0]  cstate_o,
   input  logic [2:0]  nstate_i,
   input  logic        defined_i,
   output logic [63:0] pc_o,
   output logic        trap_o,
   output logic [1:0]  cause_o,
   output logic [63:0] epc_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC
   } state_t;

   // Instruction addresses are word aligned; the low two bits never reach the bus.
   localparam logic [63:0] RESET_ADDR    = {RESET_PC[63:2], 2'b00};
   localparam logic [63:0] TRAP_ADDR     = {TRAP_PC[63:2], 2'b00};
   localparam logic [31:0] NOP           = 32'h0000_0013;
   localparam logic [2:0]  C_DECODE      = 3'd0;
   // Cycle 3 is side-effect free in the decoder, so it doubles as the
   // "parked" value while fetching and the "retire" cycle while executing.
   localparam logic [2:0]  C_RETIRE      = 3'd3;
   localparam logic [1:0]  CAUSE_NONE    = 2'd0;
   localparam logic [1:0]  CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0]  CAUSE_FAULT   = 2'd2;

   state_t      r_state;
   logic [63:0] r_pc;
   logic [31:0] r_ir;
   logic [2:0]  r_cstate;
   logic        r_trap;
   logic [1:0]  r_cause;
   logic [63:0] r_epc;

   state_t      w_state;
   logic [63:0] w_pc;
   logic [31:0] w_ir;
   logic [2:0]  w_cstate;
   logic        w_trap;
   logic [1:0]  w_cause;
   logic [63:0] w_epc;
   logic        w_trap_req;
   logic [1:0]  w_trap_cause;

   // Next-state and datapath decisions for the fetch/execute sequence.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves one unassigned and a latch is never inferred.
      w_state      = r_state;
      w_pc         = r_pc;
      w_ir         = r_ir;
      w_cstate     = r_cstate;
      w_trap       = 1'b0;
      w_cause      = r_cause;
      w_epc        = r_epc;
      w_trap_req   = 1'b0;
      w_trap_cause = CAUSE_NONE;

      case (r_state)
         S_IDLE: begin
            w_state = S_FETCH;
         end
         S_FETCH: begin
            // A bus error outranks a simultaneous acknowledge.
            if (ierr_i) begin
               w_trap_req   = 1'b1;
               w_trap_cause = CAUSE_FAULT;
            end else if (iack_i) begin
               w_ir     = idat_i;
               w_cstate = C_DECODE;
               w_state  = S_EXEC;
            end
         end
         S_EXEC: begin
            if ((r_cstate == C_DECODE) && !defined_i) begin
               w_trap_req   = 1'b1;
               w_trap_cause = CAUSE_ILLEGAL;
            end else if (r_cstate == C_RETIRE) begin
               w_pc    = r_pc + 64'd4;
               w_state = S_FETCH;
            end else begin
               w_cstate = nstate_i;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      // Both trap sources share one redirect action.
      if (w_trap_req) begin
         w_epc    = r_pc;
         w_cause  = w_trap_cause;
         w_pc     = TRAP_ADDR;
         w_trap   = 1'b1;
         w_cstate = C_RETIRE;
         w_state  = S_FETCH;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      if (reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   // PC, instruction register, decoder cycle and trap bookkeeping registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_pc     <= RESET_ADDR;
         r_ir     <= NOP;
         r_cstate <= C_RETIRE;
         r_trap   <= 1'b0;
         r_cause  <= CAUSE_NONE;
         r_epc    <= 64'd0;
      end else begin
         r_pc     <= w_pc;
         r_ir     <= w_ir;
         r_cstate <= w_cstate;
         r_trap   <= w_trap;
         r_cause  <= w_cause;
         r_epc    <= w_epc;
      end
   end

   // The strobe is a pure decode of the state, so it drops the instant reset
   // clears the state register and a late acknowledge has nothing to land on.
   assign istb_o   = (r_state == S_FETCH);
   assign iadr_o   = r_pc;
   assign pc_o     = r_pc;
   assign ir_o     = r_ir;
   assign cstate_o = r_cstate;
   assign trap_o   = r_trap;
   assign cause_o  = r_cause;
   assign epc_o    = r_epc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: randomized fetch latencies,
// decoder cycle paths and traps, checked against an architectural model
// (PC, IR, cause, EPC) kept in plain variables.
module tb_fetch_sequencer;

   localparam logic [63:0] RST_PC = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [63:0] TRP_PC = 64'hFFFF_FFFF_FFFF_FE00;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk_i;
   logic        reset_i;
   logic [63:0] iadr_o;
   logic        istb_o;
   logic        iack_i;
   logic        ierr_i;
   logic [31:0] idat_i;
   logic [31:0] ir_o;
   logic [2:0]  cstate_o;
   logic [2:0]  nstate_i;
   logic        defined_i;
   logic [63:0] pc_o;
   logic        trap_o;
   logic [1:0]  cause_o;
   logic [63:0] epc_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Architectural model
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic [1:0]  m_cause;
   logic [63:0] m_epc;

   fetch_sequencer dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .iadr_o    (iadr_o),
      .istb_o    (istb_o),
      .iack_i    (iack_i),
      .ierr_i    (ierr_i),
      .idat_i    (idat_i),
      .ir_o      (ir_o),
      .cstate_o  (cstate_o),
      .nstate_i  (nstate_i),
      .defined_i (defined_i),
      .pc_o      (pc_o),
      .trap_o    (trap_o),
      .cause_o   (cause_o),
      .epc_o     (epc_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Fetch one word at m_pc after `waits` idle strobe cycles; err raises a bus error.
   task automatic fetch_instr(input logic [31:0] word, input int waits, input logic err);
      for (int i = 0; i < waits; i++) begin
         iack_i    = 1'b0;
         ierr_i    = 1'b0;
         idat_i    = $urandom;
         nstate_i  = 3'($urandom_range(0, 7));
         defined_i = 1'($urandom_range(0, 1));
         step();
         n_checks++;
         if ({istb_o, iadr_o, cstate_o, trap_o} !== {1'b1, m_pc, 3'd3, 1'b0})
            $display("FAIL fetch_wait: istb/iadr/cstate/trap got %0b/%h/%0d/%0b want 1/%h/3/0",
                     istb_o, iadr_o, cstate_o, trap_o, m_pc);
         else n_pass++;
      end
      iack_i = 1'b1;
      ierr_i = err;
      idat_i = word;
      step();
      iack_i = 1'b0;
      ierr_i = 1'b0;
      idat_i = $urandom;
      if (err) begin
         m_epc   = m_pc;
         m_cause = 2'd2;
         m_pc    = TRP_PC;
         n_checks++;
         if ({trap_o, cause_o, epc_o} !== {1'b1, m_cause, m_epc})
            $display("FAIL fault_trap: trap/cause/epc got %0b/%0d/%h want 1/%0d/%h",
                     trap_o, cause_o, epc_o, m_cause, m_epc);
         else n_pass++;
         n_checks++;
         if ({istb_o, iadr_o, pc_o, ir_o, cstate_o} !== {1'b1, m_pc, m_pc, m_ir, 3'd3})
            $display("FAIL fault_redirect: istb/iadr/pc/ir/cstate got %0b/%h/%h/%h/%0d want 1/%h/%h/%h/3",
                     istb_o, iadr_o, pc_o, ir_o, cstate_o, m_pc, m_pc, m_ir);
         else n_pass++;
         step();
         n_checks++;
         if ({trap_o, istb_o, iadr_o} !== {1'b0, 1'b1, m_pc})
            $display("FAIL fault_pulse: trap/istb/iadr got %0b/%0b/%h want 0/1/%h",
                     trap_o, istb_o, iadr_o, m_pc);
         else n_pass++;
      end else begin
         m_ir = word;
         n_checks++;
         if ({istb_o, ir_o, cstate_o, pc_o, trap_o} !== {1'b0, m_ir, 3'd0, m_pc, 1'b0})
            $display("FAIL fetch_load: istb/ir/cstate/pc/trap got %0b/%h/%0d/%h/%0b want 0/%h/0/%h/0",
                     istb_o, ir_o, cstate_o, pc_o, trap_o, m_ir, m_pc);
         else n_pass++;
      end
   endtask

   // Execute the loaded instruction: n_mid intermediate decoder cycles then
   // cycle 3 and retire; an undefined instruction traps instead.
   task automatic exec_instr(input int n_mid, input bit ascending, input logic legal);
      logic [2:0] ns;
      if (!legal) begin
         defined_i = 1'b0;
         nstate_i  = 3'($urandom_range(1, 3));
         step();
         defined_i = 1'b1;
         m_epc   = m_pc;
         m_cause = 2'd1;
         m_pc    = TRP_PC;
         n_checks++;
         if ({trap_o, cause_o, epc_o} !== {1'b1, m_cause, m_epc})
            $display("FAIL illegal_trap: trap/cause/epc got %0b/%0d/%h want 1/%0d/%h",
                     trap_o, cause_o, epc_o, m_cause, m_epc);
         else n_pass++;
         n_checks++;
         if ({istb_o, iadr_o, pc_o, ir_o, cstate_o} !== {1'b1, m_pc, m_pc, m_ir, 3'd3})
            $display("FAIL illegal_redirect: istb/iadr/pc/ir/cstate got %0b/%h/%h/%h/%0d want 1/%h/%h/%h/3",
                     istb_o, iadr_o, pc_o, ir_o, cstate_o, m_pc, m_pc, m_ir);
         else n_pass++;
         step();
         n_checks++;
         if ({trap_o, istb_o, iadr_o} !== {1'b0, 1'b1, m_pc})
            $display("FAIL illegal_pulse: trap/istb/iadr got %0b/%0b/%h want 0/1/%h",
                     trap_o, istb_o, iadr_o, m_pc);
         else n_pass++;
      end else begin
         for (int i = 0; i <= n_mid; i++) begin
            if (i == n_mid) ns = 3'd3;
            else if (ascending) ns = 3'(i + 1);
            else ns = 3'($urandom_range(1, 2));
            nstate_i  = ns;
            defined_i = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if ({cstate_o, istb_o, trap_o, pc_o} !== {ns, 1'b0, 1'b0, m_pc})
               $display("FAIL exec_step: cstate/istb/trap/pc got %0d/%0b/%0b/%h want %0d/0/0/%h",
                        cstate_o, istb_o, trap_o, pc_o, ns, m_pc);
            else n_pass++;
         end
         nstate_i  = 3'($urandom_range(0, 2));
         defined_i = 1'($urandom_range(0, 1));
         step();
         m_pc = m_pc + 64'd4;
         n_checks++;
         if ({istb_o, iadr_o, pc_o, cstate_o, ir_o, trap_o} !== {1'b1, m_pc, m_pc, 3'd3, m_ir, 1'b0})
            $display("FAIL retire: istb/iadr/pc/cstate/ir/trap got %0b/%h/%h/%0d/%h/%0b want 1/%h/%h/3/%h/0",
                     istb_o, iadr_o, pc_o, cstate_o, ir_o, trap_o, m_pc, m_pc, m_ir);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      reset_i   = 1'b1;
      iack_i    = 1'b0;
      ierr_i    = 1'b0;
      idat_i    = 32'd0;
      nstate_i  = 3'd0;
      defined_i = 1'b1;
      m_pc = RST_PC; m_ir = NOP; m_cause = 2'd0; m_epc = 64'd0;
      #3;
      n_checks++;
      if ({istb_o, iadr_o, pc_o, ir_o, cstate_o, trap_o, cause_o, epc_o} !==
          {1'b0, RST_PC, RST_PC, NOP, 3'd3, 1'b0, 2'd0, 64'd0})
         $display("FAIL reset_values: istb/iadr/pc/ir/cstate/trap/cause/epc got %0b/%h/%h/%h/%0d/%0b/%0d/%h",
                  istb_o, iadr_o, pc_o, ir_o, cstate_o, trap_o, cause_o, epc_o);
      else n_pass++;
      iack_i = 1'b1;
      step();
      iack_i = 1'b0;
      n_checks++;
      if ({istb_o, ir_o, cstate_o} !== {1'b0, NOP, 3'd3})
         $display("FAIL reset_hold: istb/ir/cstate got %0b/%h/%0d want 0/%h/3", istb_o, ir_o, cstate_o, NOP);
      else n_pass++;
      reset_i = 1'b0;
      step();
      n_checks++;
      if ({istb_o, iadr_o, cstate_o} !== {1'b1, RST_PC, 3'd3})
         $display("FAIL reset_release: istb/iadr/cstate got %0b/%h/%0d want 1/%h/3", istb_o, iadr_o, cstate_o, RST_PC);
      else n_pass++;
   endtask

   task automatic test_first_fetch();
      fetch_instr(32'h0420_0093, 0, 1'b0);
      exec_instr(2, 1'b1, 1'b1);
      n_checks++;
      if (iadr_o !== 64'hFFFF_FFFF_FFFF_FF04)
         $display("FAIL first_next_addr: got %h want ffffffffffffff04", iadr_o);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      fetch_instr($urandom, 5, 1'b0);
      exec_instr($urandom_range(0, 2), 1'b0, 1'b1);
   endtask

   task automatic test_illegal();
      fetch_instr(32'hFFFF_FFFF, 0, 1'b0);
      exec_instr(0, 1'b0, 1'b0);
      n_checks++;
      if ({cause_o, epc_o, iadr_o} !== {2'd1, 64'hFFFF_FFFF_FFFF_FF08, TRP_PC})
         $display("FAIL illegal_abs: cause/epc/iadr got %0d/%h/%h want 1/ffffffffffffff08/%h",
                  cause_o, epc_o, iadr_o, TRP_PC);
      else n_pass++;
   endtask

   task automatic test_fetch_fault();
      fetch_instr(NOP, $urandom_range(0, 2), 1'b1);
      n_checks++;
      if ({cause_o, epc_o, ir_o, iadr_o} !== {2'd2, TRP_PC, 32'hFFFF_FFFF, TRP_PC})
         $display("FAIL fault_abs: cause/epc/ir/iadr got %0d/%h/%h/%h want 2/%h/ffffffff/%h",
                  cause_o, epc_o, ir_o, iadr_o, TRP_PC, TRP_PC);
      else n_pass++;
      fetch_instr($urandom, 0, 1'b0);
      exec_instr($urandom_range(0, 3), 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic err;
      for (int k = 0; k < 60; k++) begin
         err = ($urandom_range(0, 9) == 0);
         fetch_instr($urandom, $urandom_range(0, 3), err);
         if (!err) exec_instr($urandom_range(0, 3), 1'b0, ($urandom_range(0, 9) != 0));
      end
   endtask

   task automatic test_wrap();
      int budget = 200;
      while ((m_pc != 64'd0) && (budget > 0)) begin
         fetch_instr($urandom, $urandom_range(0, 1), 1'b0);
         exec_instr($urandom_range(0, 1), 1'b0, 1'b1);
         budget--;
      end
      n_checks++;
      if ({pc_o, iadr_o, istb_o} !== {64'd0, 64'd0, 1'b1})
         $display("FAIL pc_wrap: pc/iadr/istb got %h/%h/%0b want 0/0/1 (budget left %0d)",
                  pc_o, iadr_o, istb_o, budget);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fetch();
      iack_i = 1'b0;
      step();
      #2;
      reset_i = 1'b1;
      iack_i  = 1'b1;
      idat_i  = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if ({istb_o, iadr_o, pc_o, ir_o, cstate_o, trap_o, cause_o, epc_o} !==
          {1'b0, RST_PC, RST_PC, NOP, 3'd3, 1'b0, 2'd0, 64'd0})
         $display("FAIL reset_mid_fetch: istb/iadr/pc/ir/cstate/trap/cause/epc got %0b/%h/%h/%h/%0d/%0b/%0d/%h",
                  istb_o, iadr_o, pc_o, ir_o, cstate_o, trap_o, cause_o, epc_o);
      else n_pass++;
      step();
      iack_i  = 1'b0;
      reset_i = 1'b0;
      m_pc = RST_PC; m_ir = NOP; m_cause = 2'd0; m_epc = 64'd0;
      n_checks++;
      if ({istb_o, ir_o} !== {1'b0, NOP})
         $display("FAIL reset_late_ack: istb/ir got %0b/%h want 0/%h", istb_o, ir_o, NOP);
      else n_pass++;
      step();
      n_checks++;
      if ({istb_o, iadr_o, ir_o} !== {1'b1, RST_PC, NOP})
         $display("FAIL reset_fetch_restart: istb/iadr/ir got %0b/%h/%h want 1/%h/%h", istb_o, iadr_o, ir_o, RST_PC, NOP);
      else n_pass++;
   endtask

   task automatic test_reset_mid_exec();
      // Leave a trap record so reset has something to clear.
      fetch_instr($urandom, 0, 1'b1);
      fetch_instr($urandom, 0, 1'b0);
      nstate_i  = 3'd2;
      defined_i = 1'b1;
      step();
      n_checks++;
      if (cstate_o !== 3'd2)
         $display("FAIL mid_exec_setup: cstate got %0d want 2", cstate_o);
      else n_pass++;
      #2;
      reset_i = 1'b1;
      #1;
      n_checks++;
      if ({istb_o, iadr_o, pc_o, ir_o, cstate_o, trap_o, cause_o, epc_o} !==
          {1'b0, RST_PC, RST_PC, NOP, 3'd3, 1'b0, 2'd0, 64'd0})
         $display("FAIL reset_mid_exec: istb/iadr/pc/ir/cstate/trap/cause/epc got %0b/%h/%h/%h/%0d/%0b/%0d/%h",
                  istb_o, iadr_o, pc_o, ir_o, cstate_o, trap_o, cause_o, epc_o);
      else n_pass++;
      step();
      reset_i = 1'b0;
      m_pc = RST_PC; m_ir = NOP; m_cause = 2'd0; m_epc = 64'd0;
      step();
      fetch_instr($urandom, $urandom_range(0, 2), 1'b0);
      exec_instr($urandom_range(0, 2), 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_wait_states();
      test_illegal();
      test_fetch_fault();
      test_random();
      test_wrap();
      test_reset_mid_fetch();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
